// File: rtl/my_logic_op_pipe.sv
// Two-stage valid/ready pipeline that reduces NUM_INPUTS operand channels with a
// selectable bitwise AND/OR/XOR/NAND and counts delivered results (wrapping).
module my_logic_op_pipe #(
  parameter int INPUT_WIDTH = 1,
  parameter int NUM_INPUTS  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clock_in,
  input  logic                              reset_n_in,
  input  logic [NUM_INPUTS*INPUT_WIDTH-1:0] operands_in,
  input  logic [1:0]                        op_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [INPUT_WIDTH-1:0]            c_out,
  output logic                              zero_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic [COUNT_WIDTH-1:0]            result_count_out
);

  localparam int unsigned NI = NUM_INPUTS;
  localparam int unsigned IW = INPUT_WIDTH;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic [NUM_INPUTS*INPUT_WIDTH-1:0] s1_operands;
  logic [1:0]                        s1_op;
  logic                              v1;
  logic                              s1_load;
  logic                              s2_load;

  logic [INPUT_WIDTH-1:0] red_and;
  logic [INPUT_WIDTH-1:0] red_or;
  logic [INPUT_WIDTH-1:0] red_xor;
  logic [INPUT_WIDTH-1:0] result;

  // An empty stage always loads, so bubbles collapse even under a downstream stall.
  assign s2_load   = ~valid_out | ready_in;
  assign s1_load   = ~v1 | s2_load;
  assign ready_out = s1_load;

  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int unsigned k = 0; k < NI; k++) begin
      red_and = red_and & s1_operands[k*IW +: IW];
      red_or  = red_or  | s1_operands[k*IW +: IW];
      red_xor = red_xor ^ s1_operands[k*IW +: IW];
    end
  end

  always_comb begin
    result = '0;
    case (s1_op)
      OP_AND:  result = red_and;
      OP_OR:   result = red_or;
      OP_XOR:  result = red_xor;
      OP_NAND: result = ~red_and;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      s1_operands      <= '0;
      s1_op            <= '0;
      v1               <= 1'b0;
      c_out            <= '0;
      zero_out         <= 1'b0;
      valid_out        <= 1'b0;
      result_count_out <= '0;
    end else begin
      if (s1_load) begin
        s1_operands <= operands_in;
        s1_op       <= op_in;
        v1          <= valid_in;
      end
      if (s2_load) begin
        c_out     <= result;
        zero_out  <= (result == '0);
        valid_out <= v1;
      end
      if (valid_out && ready_in) begin
        result_count_out <= result_count_out + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_my_logic_op_pipe.sv
// Scoreboard bench for my_logic_op_pipe: driver pushes reference results on accept,
// a negedge monitor pops and compares on every delivery.
module tb_my_logic_op_pipe;

  localparam int IW = 4;
  localparam int NI = 3;
  localparam int CW = 2;

  logic                clock_in = 1'b0;
  logic                reset_n_in;
  logic [NI*IW-1:0]    operands_in;
  logic [1:0]          op_in;
  logic                valid_in;
  logic                ready_out;
  logic [IW-1:0]       c_out;
  logic                zero_out;
  logic                valid_out;
  logic                ready_in;
  logic [CW-1:0]       result_count_out;

  my_logic_op_pipe #(
    .INPUT_WIDTH(IW),
    .NUM_INPUTS (NI),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock_in        (clock_in),
    .reset_n_in      (reset_n_in),
    .operands_in     (operands_in),
    .op_in           (op_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .c_out           (c_out),
    .zero_out        (zero_out),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .result_count_out(result_count_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [IW-1:0] c;
    logic          z;
    int            cyc;
    bit            strict;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mcount = 0;
  bit   strict_lat = 1'b0;

  // Per bit: count ones across channels, then apply the operation's rule.
  function automatic exp_t ref_model(input logic [NI*IW-1:0] ops, input logic [1:0] op);
    exp_t e;
    e.c = '0;
    for (int b = 0; b < IW; b++) begin
      int ones = 0;
      for (int k = 0; k < NI; k++) ones += ops[k*IW + b] ? 1 : 0;
      case (op)
        2'd0:    e.c[b] = (ones == NI);
        2'd1:    e.c[b] = (ones > 0);
        2'd2:    e.c[b] = (ones % 2 == 1);
        default: e.c[b] = (ones != NI);
      endcase
    end
    e.z = (e.c == '0);
    e.cyc = 0;
    e.strict = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, where inputs and outputs are stable.
  initial begin
    bit            rst_prev = 1'b1;
    bit            held_prev = 1'b0;
    logic [IW-1:0] prev_c = '0;
    logic          prev_z = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clock_in);
      cyc++;
      if (!rst_prev) begin
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_zero_out", 32'(zero_out), 32'd0);
        chk("rst_count", 32'(result_count_out), 32'd0);
        if (reset_n_in) chk("ready_after_reset", 32'(ready_out), 32'd1);
      end
      if (!reset_n_in) begin
        q.delete();
        mcount = 0;
        held_prev = 1'b0;
      end else begin
        if (valid_out) chk("no_spurious_valid", 32'(q.size() > 0), 32'd1);
        if (held_prev) begin
          chk("hold_valid", 32'(valid_out), 32'd1);
          chk("hold_c", 32'(c_out), 32'(prev_c));
          chk("hold_zero", 32'(zero_out), 32'(prev_z));
        end
        if (valid_out && ready_in && q.size() > 0) begin
          e = q.pop_front();
          chk("c_out", 32'(c_out), 32'(e.c));
          chk("zero_out", 32'(zero_out), 32'(e.z));
          chk("count", 32'(result_count_out), 32'(mcount));
          chk("latency_min", 32'(cyc - e.cyc >= 2), 32'd1);
          if (e.strict) chk("latency_exact", 32'(cyc - e.cyc), 32'd2);
          mcount = (mcount + 1) % (1 << CW);
        end
        if (valid_in && ready_out) begin
          e = ref_model(operands_in, op_in);
          e.cyc = cyc;
          e.strict = strict_lat;
          q.push_back(e);
        end
        held_prev = valid_out && !ready_in;
        prev_c = c_out;
        prev_z = zero_out;
      end
      rst_prev = reset_n_in;
    end
  end

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // Presents one transaction and holds it until accepted (bounded).
  task automatic send(input logic [NI*IW-1:0] ops, input logic [1:0] op);
    bit ok = 1'b0;
    operands_in = ops;
    op_in = op;
    valid_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock_in);
      if (ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_accept_timeout", 32'd0, 32'd1);
    step();
    valid_in = 1'b0;
  endtask

  initial begin
    bit drained;
    reset_n_in = 1'b0;
    valid_in = 1'b1;
    ready_in = 1'b1;
    operands_in = 12'h5A3;
    op_in = 2'b00;
    repeat (3) @(posedge clock_in);
    #1;
    reset_n_in = 1'b1;
    valid_in = 1'b0;
    step();

    // All four ops on the same operands, back to back.
    strict_lat = 1'b1;
    for (int op = 0; op < 4; op++) begin
      operands_in = {4'hC, 4'hA, 4'h6};
      op_in = 2'(op);
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    repeat (4) step();
    strict_lat = 1'b0;

    // Backpressure: two accepted, the third must see ready_out low.
    ready_in = 1'b0;
    send({4'h1, 4'h2, 4'h3}, 2'b01);
    send({4'hF, 4'h7, 4'h3}, 2'b00);
    operands_in = {4'h9, 4'h5, 4'hE};
    op_in = 2'b10;
    valid_in = 1'b1;
    #1;
    chk("ready_out_full", 32'(ready_out), 32'd0);
    repeat (3) step();
    ready_in = 1'b1;
    send({4'h9, 4'h5, 4'hE}, 2'b10);
    repeat (4) step();

    // Bubbles with toggling consumer.
    for (int i = 0; i < 6; i++) begin
      valid_in = (i % 3 != 1);
      operands_in = 12'($urandom());
      op_in = 2'($urandom());
      ready_in = (i % 2 == 1);
      step();
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (4) step();

    // Reset with both stages full; flushed results must never show up.
    ready_in = 1'b0;
    send({4'h8, 4'h4, 4'h2}, 2'b01);
    send({4'h0, 4'h0, 4'h0}, 2'b11);
    reset_n_in = 1'b0;
    step();
    reset_n_in = 1'b1;
    ready_in = 1'b1;
    repeat (4) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      valid_in = ($urandom_range(3) != 0);
      operands_in = 12'($urandom());
      op_in = 2'($urandom());
      ready_in = ($urandom_range(2) != 0);
      reset_n_in = ($urandom_range(149) != 0);
      step();
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    reset_n_in = 1'b1;

    drained = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (q.size() == 0 && !valid_out) begin
        drained = 1'b1;
        break;
      end
    end
    chk("drain", 32'(drained), 32'd1);
    @(negedge clock_in);
    #1;
    chk("final_count", 32'(result_count_out), 32'(mcount));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_logic_op_pipe.md
# my_logic_op_pipe

Parametrised, pipelined successor to the single-bit registered AND gate: reduces NUM_INPUTS operand channels of INPUT_WIDTH bits with a run-time selectable bitwise operation (AND, OR, XOR, NAND). A valid/ready handshake provides backpressure, and the block keeps a wrapping count of delivered results. It sits between a producer and a consumer stream in the Zedboard test fabric, replacing hard-wired gate instances.

## Interface
- INPUT_WIDTH, 1, bits per operand channel and result width (>= 1)
- NUM_INPUTS, 2, number of operand channels reduced (>= 2)
- COUNT_WIDTH, 16, width of delivered-result counter (>= 1)
- clock_in  input  1  single clock, all state on rising edge
- reset_n_in  input  1  reset, synchronous, active-low
- operands_in  input  NUM_INPUTS*INPUT_WIDTH  packed operands; channel k = bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- op_in  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND
- valid_in  input  1  operands_in/op_in valid
- ready_out  output  1  block accepts this cycle
- c_out  output  INPUT_WIDTH  registered result
- zero_out  output  1  registered flag, c_out == 0
- valid_out  output  1  c_out/zero_out valid
- ready_in  input  1  consumer accepts this cycle
- result_count_out  output  COUNT_WIDTH  number of results delivered, wraps

## Operation
- One clock (clock_in); reset synchronous, active-low (reset_n_in). Reset sampled on the rising edge only.
- Two register stages. S1 holds operands + op + v1. S2 holds result, zero flag, v2.
- Input accept: valid_in & ready_out. Output delivery: valid_out & ready_in.
- s2_load = ~v2 | ready_in. s1_load = ~v1 | s2_load. ready_out = s1_load.
- On s1_load: S1 captures operands_in/op_in; v1 <= valid_in & ready_out.
- On s2_load: S2 captures f(S1); v2 <= v1.
- Bubbles collapse: an empty stage loads regardless of downstream stall.
- f: bitwise reduction over all NUM_INPUTS channels. AND = &, OR = |, XOR = ^ (odd parity per bit), NAND = ~(AND of all channels). The op is sampled with its own operands, so a per-transaction op change is legal.
- zero_out = (f == 0), registered alongside c_out.
- Held data: while valid_out & ~ready_in, c_out, zero_out and valid_out stay constant. S1 also holds if v1 is set.
- result_count_out increments by 1 on each delivery. It wraps from 2^COUNT_WIDTH-1 to 0 and does not saturate.
- Reset values: v1=0, v2=0, valid_out=0, c_out=0, zero_out=0, result_count_out=0. ready_out is 1 in the first cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded and the counter is cleared. No partial result is emitted.
- While reset_n_in=0, ready_out may be high, but nothing is accepted.

## Timing
- Latency: accepted at edge N, valid_out high after edge N+1 (2-edge pipeline, result visible the cycle after it leaves S1).
- Throughput: 1 transaction per cycle while ready_in=1.
- Capacity: 2 transactions with ready_in=0. ready_out falls the cycle after both stages fill.
- ready_out depends combinationally on ready_in (through s2_load). No other input-to-output combinational paths exist.
- Simultaneous accept and deliver in one cycle is legal and loses no data.

## Test plan
- Reset: hold reset_n_in=0 for 3 edges with valid_in=1 -> valid_out=0, c_out=0, result_count_out=0. First ready_out=1 after release.
- Ops, INPUT_WIDTH=4, NUM_INPUTS=3, operands {4'hC,4'hA,4'h6}, ready_in=1, op 00/01/10/11 on consecutive cycles -> c_out 4'h0 (zero_out=1), 4'hE, 4'h0 (zero_out=1), 4'hF. Each appears exactly 2 edges after its accept. result_count_out ends at 4.
- Backpressure: ready_in=0, stream 3 distinct transactions -> first two accepted, ready_out=0 on the third. valid_out held with first result stable. Raise ready_in -> all 3 results delivered in order with no loss or duplication.
- Bubbles: valid_in pattern 1,0,1 with ready_in toggling 0,1 -> results in order, no spurious valid_out.
- Wrap: COUNT_WIDTH=2, deliver 5 results -> result_count_out sequence 1,2,3,0,1.
- Reset mid-stream: assert reset_n_in with both stages full -> next cycle valid_out=0 and result_count_out=0. The flushed results never appear.
